// File: rtl/fpga_ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, requester indices, read-return tag.
// Round-robin tie-break is enabled by defining FPGA_RAM_ARB_RR_EN.
package fpga_ram_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Identifies which port, if any, is owed read data on the next cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_M0   = 2'd1,
    TAG_M1   = 2'd2
  } rtag_e;

  function automatic rtag_e read_tag(input logic owner);
    return owner ? TAG_M1 : TAG_M0;
  endfunction

endpackage

// File: rtl/fpga_ram_arb_pick.sv
// Combinational 2-way grant pick from requests, lock state/owner and (optionally) last-grant pointer.
// FPGA_RAM_ARB_RR_EN selects round-robin ties; otherwise M0 wins every IDLE tie.
module fpga_ram_arb_pick
  import fpga_ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  state_e     i_state,
  input  logic       i_owner,
`ifdef FPGA_RAM_ARB_RR_EN
  input  logic       i_last,
`endif
  output logic [1:0] o_gnt
);

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_gnt = 2'b00;
    if (i_state == ST_LOCKED) begin
      o_gnt[i_owner] = i_req[i_owner];
    end else if (i_req == 2'b11) begin
`ifdef FPGA_RAM_ARB_RR_EN
      o_gnt[~i_last] = 1'b1;
`else
      o_gnt[M0] = 1'b1;
`endif
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/fpga_ram_arb.sv
// Two-requester arbiter in front of a single-port RAM with lock ownership and idle-lock timeout.
// Optional round-robin tie-break: define FPGA_RAM_ARB_RR_EN.
module fpga_ram_arb
  import fpga_ram_arb_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 10,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 M0Req,
  input  logic                 M0Lock,
  input  logic [ADDRWIDTH-1:0] M0Addr,
  input  logic [DATAWIDTH-1:0] M0WData,
  input  logic                 M0We,
  output logic                 M0Gnt,
  output logic                 M0RValid,
  output logic [DATAWIDTH-1:0] M0RData,
  input  logic                 M1Req,
  input  logic                 M1Lock,
  input  logic [ADDRWIDTH-1:0] M1Addr,
  input  logic [DATAWIDTH-1:0] M1WData,
  input  logic                 M1We,
  output logic                 M1Gnt,
  output logic                 M1RValid,
  output logic [DATAWIDTH-1:0] M1RData,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [DATAWIDTH-1:0] RamDataIn,
  output logic                 RamWriteEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut
);

  // Counter only needs 0..LOCK_TIMEOUT-1: reaching the limit releases and clears in the same edge.
  localparam int CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  state_e        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;
  logic [CW-1:0] r_idle_cnt, w_idle_cnt_nxt;
  rtag_e         r_rtag, w_rtag_nxt;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_xfer;
  logic       w_sel;
  logic       w_sel_lock;
  logic       w_sel_we;

  assign w_req = {M1Req, M0Req};

`ifdef FPGA_RAM_ARB_RR_EN
  logic r_last;
  logic w_last_nxt;

  assign w_last_nxt = w_xfer ? w_sel : r_last;
`endif

  fpga_ram_arb_pick u_pick (
    .i_req   (w_req),
    .i_state (r_state),
    .i_owner (r_owner),
`ifdef FPGA_RAM_ARB_RR_EN
    .i_last  (r_last),
`endif
    .o_gnt   (w_gnt)
  );

  assign M0Gnt      = w_gnt[M0];
  assign M1Gnt      = w_gnt[M1];
  assign w_xfer     = |w_gnt;
  assign w_sel      = w_gnt[M1];
  assign w_sel_lock = w_sel ? M1Lock : M0Lock;
  assign w_sel_we   = w_sel ? M1We   : M0We;

  always_comb begin
    RamAddr        = '0;
    RamDataIn      = '0;
    RamWriteEnable = 1'b0;
    if (w_xfer) begin
      RamAddr        = w_sel ? M1Addr  : M0Addr;
      RamDataIn      = w_sel ? M1WData : M0WData;
      RamWriteEnable = w_sel_we;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_idle_cnt_nxt = r_idle_cnt;
    w_rtag_nxt     = TAG_NONE;
    if (w_xfer && !w_sel_we) begin
      w_rtag_nxt = read_tag(w_sel);
    end
    case (r_state)
      ST_IDLE: begin
        w_idle_cnt_nxt = '0;
        if (w_xfer && w_sel_lock) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_sel;
        end
      end
      ST_LOCKED: begin
        // In LOCKED only the owner can be granted, so no transfer means the owner is idle.
        if (w_xfer) begin
          w_idle_cnt_nxt = '0;
          if (!w_sel_lock) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_idle_cnt == CNT_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_idle_cnt_nxt = '0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_idle_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= M0;
      r_idle_cnt <= '0;
      r_rtag     <= TAG_NONE;
`ifdef FPGA_RAM_ARB_RR_EN
      r_last     <= M1;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_rtag     <= w_rtag_nxt;
`ifdef FPGA_RAM_ARB_RR_EN
      r_last     <= w_last_nxt;
`endif
    end
  end

  assign M0RValid = (r_rtag == TAG_M0);
  assign M1RValid = (r_rtag == TAG_M1);
  assign M0RData  = RamDataOut;
  assign M1RData  = RamDataOut;

endmodule

// File: tb/tb_fpga_ram_arb.sv
// Directed bench for fpga_ram_arb with a registered single-port RAM model; LOCK_TIMEOUT=4.
// Expected grant order follows FPGA_RAM_ARB_RR_EN when it is defined.
module tb_fpga_ram_arb;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LT = 4;
`ifdef FPGA_RAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          Clk;
  logic          Rst;
  logic          M0Req, M0Lock, M0We, M0Gnt, M0RValid;
  logic [AW-1:0] M0Addr;
  logic [DW-1:0] M0WData, M0RData;
  logic          M1Req, M1Lock, M1We, M1Gnt, M1RValid;
  logic [AW-1:0] M1Addr;
  logic [DW-1:0] M1WData, M1RData;
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamDataIn;
  logic          RamWriteEnable;
  logic [DW-1:0] RamDataOut;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_pass  = 0;
  int n_total = 0;

  fpga_ram_arb #(
    .DATAWIDTH    (DW),
    .ADDRWIDTH    (AW),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .M0Req          (M0Req),
    .M0Lock         (M0Lock),
    .M0Addr         (M0Addr),
    .M0WData        (M0WData),
    .M0We           (M0We),
    .M0Gnt          (M0Gnt),
    .M0RValid       (M0RValid),
    .M0RData        (M0RData),
    .M1Req          (M1Req),
    .M1Lock         (M1Lock),
    .M1Addr         (M1Addr),
    .M1WData        (M1WData),
    .M1We           (M1We),
    .M1Gnt          (M1Gnt),
    .M1RValid       (M1RValid),
    .M1RData        (M1RData),
    .RamAddr        (RamAddr),
    .RamDataIn      (RamDataIn),
    .RamWriteEnable (RamWriteEnable),
    .RamDataOut     (RamDataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered single-port RAM: read data appears one cycle later, held on write cycles.
  always @(posedge Clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (RamWriteEnable) begin
      mem[RamAddr] <= RamDataIn;
    end else begin
      RamDataOut <= mem[RamAddr];
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic lock, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    M0Req = req; M0Lock = lock; M0We = we; M0Addr = addr; M0WData = data;
  endtask

  task automatic set_m1(input logic req, input logic lock, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    M1Req = req; M1Lock = lock; M1We = we; M1Addr = addr; M1WData = data;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    step();
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    Rst = 1'b1;
    step();
    step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step();
    preload(10'h005, 32'hDEADBEEF);
    preload(10'h001, 32'h11111111);
    preload(10'h002, 32'h22222222);
    n_total++; if (M0Gnt !== 1'b0) $display("FAIL reset_m0gnt: got %b want 0", M0Gnt); else n_pass++;
    n_total++; if (M1Gnt !== 1'b0) $display("FAIL reset_m1gnt: got %b want 0", M1Gnt); else n_pass++;
    n_total++; if (M0RValid !== 1'b0) $display("FAIL reset_m0rvalid: got %b want 0", M0RValid); else n_pass++;
    n_total++; if (M1RValid !== 1'b0) $display("FAIL reset_m1rvalid: got %b want 0", M1RValid); else n_pass++;
    n_total++; if (RamWriteEnable !== 1'b0) $display("FAIL reset_ramwe: got %b want 0", RamWriteEnable); else n_pass++;
    n_total++; if (RamAddr !== 10'h000) $display("FAIL reset_ramaddr: got %h want 000", RamAddr); else n_pass++;
    Rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_m0(1, 0, 0, 10'h005, 32'h0);
    #1;
    n_total++; if (M0Gnt !== 1'b1) $display("FAIL rd_m0gnt: got %b want 1", M0Gnt); else n_pass++;
    n_total++; if (M1Gnt !== 1'b0) $display("FAIL rd_m1gnt: got %b want 0", M1Gnt); else n_pass++;
    n_total++; if (RamAddr !== 10'h005) $display("FAIL rd_ramaddr: got %h want 005", RamAddr); else n_pass++;
    n_total++; if (RamWriteEnable !== 1'b0) $display("FAIL rd_ramwe: got %b want 0", RamWriteEnable); else n_pass++;
    step();
    set_m0(0, 0, 0, '0, '0);
    n_total++; if (M0RValid !== 1'b1) $display("FAIL rd_m0rvalid: got %b want 1", M0RValid); else n_pass++;
    n_total++; if (M0RData !== 32'hDEADBEEF) $display("FAIL rd_m0rdata: got %h want deadbeef", M0RData); else n_pass++;
    n_total++; if (M1RValid !== 1'b0) $display("FAIL rd_m1rvalid: got %b want 0", M1RValid); else n_pass++;
    step();
    n_total++; if (M0RValid !== 1'b0) $display("FAIL rd_m0rvalid_drop: got %b want 0", M0RValid); else n_pass++;
  endtask

  task automatic test_lock();
    // Beat 1: M1 locked write, M0 not yet asking.
    set_m1(1, 1, 1, 10'h010, 32'h3);
    #1;
    n_total++; if (M1Gnt !== 1'b1) $display("FAIL lk_m1gnt_wr: got %b want 1", M1Gnt); else n_pass++;
    n_total++; if (RamWriteEnable !== 1'b1) $display("FAIL lk_ramwe: got %b want 1", RamWriteEnable); else n_pass++;
    n_total++; if (RamDataIn !== 32'h3) $display("FAIL lk_ramdin: got %h want 3", RamDataIn); else n_pass++;
    n_total++; if (RamAddr !== 10'h010) $display("FAIL lk_ramaddr: got %h want 010", RamAddr); else n_pass++;
    step();
    set_m1(0, 0, 0, '0, '0);
    set_m0(1, 0, 0, 10'h010, 32'h0);
    #1;
    n_total++; if (M0Gnt !== 1'b0) $display("FAIL lk_m0gnt_blocked: got %b want 0", M0Gnt); else n_pass++;
    n_total++; if (M1RValid !== 1'b0) $display("FAIL lk_wr_no_rvalid: got %b want 0", M1RValid); else n_pass++;
    step();
    set_m1(1, 0, 0, 10'h010, 32'h0);
    #1;
    n_total++; if (M1Gnt !== 1'b1) $display("FAIL lk_m1gnt_unlock: got %b want 1", M1Gnt); else n_pass++;
    n_total++; if (M0Gnt !== 1'b0) $display("FAIL lk_m0gnt_still_blocked: got %b want 0", M0Gnt); else n_pass++;
    step();
    set_m1(0, 0, 0, '0, '0);
    #1;
    n_total++; if (M0Gnt !== 1'b1) $display("FAIL lk_m0gnt_released: got %b want 1", M0Gnt); else n_pass++;
    n_total++; if (M1RValid !== 1'b1) $display("FAIL lk_m1rvalid: got %b want 1", M1RValid); else n_pass++;
    n_total++; if (M1RData !== 32'h3) $display("FAIL lk_m1rdata: got %h want 3", M1RData); else n_pass++;
    n_total++; if (M0RValid !== 1'b0) $display("FAIL lk_m0rvalid_early: got %b want 0", M0RValid); else n_pass++;
    step();
    set_m0(0, 0, 0, '0, '0);
    n_total++; if (M0RValid !== 1'b1) $display("FAIL lk_m0rvalid: got %b want 1", M0RValid); else n_pass++;
    n_total++; if (M0RData !== 32'h3) $display("FAIL lk_m0rdata: got %h want 3", M0RData); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] win;
    logic       prev;
    // Winner per cycle: alternating from M0 with round-robin, otherwise always M0.
    win = RR_EN ? 4'b1010 : 4'b0000;
    prev = 1'b0;
    do_reset();
    set_m0(1, 0, 0, 10'h001, 32'h0);
    set_m1(1, 0, 0, 10'h002, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        set_m0(0, 0, 0, '0, '0);
        set_m1(0, 0, 0, '0, '0);
      end
      #1;
      if (i < 4) begin
        n_total++; if (M0Gnt !== ~win[i]) $display("FAIL b2b_m0gnt[%0d]: got %b want %b", i, M0Gnt, ~win[i]); else n_pass++;
        n_total++; if (M1Gnt !== win[i]) $display("FAIL b2b_m1gnt[%0d]: got %b want %b", i, M1Gnt, win[i]); else n_pass++;
      end
      if (i > 0) begin
        n_total++; if (M0RValid !== ~prev) $display("FAIL b2b_m0rvalid[%0d]: got %b want %b", i, M0RValid, ~prev); else n_pass++;
        n_total++; if (M1RValid !== prev) $display("FAIL b2b_m1rvalid[%0d]: got %b want %b", i, M1RValid, prev); else n_pass++;
        if (prev) begin
          n_total++; if (M1RData !== 32'h22222222) $display("FAIL b2b_m1rdata[%0d]: got %h want 22222222", i, M1RData); else n_pass++;
        end else begin
          n_total++; if (M0RData !== 32'h11111111) $display("FAIL b2b_m0rdata[%0d]: got %h want 11111111", i, M0RData); else n_pass++;
        end
      end
      if (i < 4) prev = win[i];
      step();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_m0(1, 1, 0, 10'h000, 32'h0);
    set_m1(1, 0, 0, 10'h002, 32'h0);
    #1;
    n_total++; if (M0Gnt !== 1'b1) $display("FAIL to_m0gnt_lock: got %b want 1", M0Gnt); else n_pass++;
    n_total++; if (M1Gnt !== 1'b0) $display("FAIL to_m1gnt_tie: got %b want 0", M1Gnt); else n_pass++;
    step();
    set_m0(0, 0, 0, '0, '0);
    for (int i = 1; i <= LT; i++) begin
      #1;
      n_total++; if (M1Gnt !== 1'b0) $display("FAIL to_m1gnt_idle[%0d]: got %b want 0", i, M1Gnt); else n_pass++;
      step();
    end
    #1;
    n_total++; if (M1Gnt !== 1'b1) $display("FAIL to_m1gnt_after: got %b want 1", M1Gnt); else n_pass++;
    n_total++; if (M0Gnt !== 1'b0) $display("FAIL to_m0gnt_after: got %b want 0", M0Gnt); else n_pass++;
    step();
    set_m1(0, 0, 0, '0, '0);
    step();
  endtask

  task automatic test_reset_during_read();
    do_reset();
    set_m0(1, 0, 0, 10'h005, 32'h0);
    #1;
    n_total++; if (M0Gnt !== 1'b1) $display("FAIL rr_m0gnt_read: got %b want 1", M0Gnt); else n_pass++;
    step();
    set_m0(0, 0, 0, '0, '0);
    Rst = 1'b1;
    #1;
    n_total++; if (M0RValid !== 1'b0) $display("FAIL rr_m0rvalid_suppressed: got %b want 0", M0RValid); else n_pass++;
    step();
    Rst = 1'b0;
    set_m0(1, 0, 0, 10'h005, 32'h0);
    set_m1(1, 0, 0, 10'h002, 32'h0);
    #1;
    n_total++; if (M0RValid !== 1'b0) $display("FAIL rr_m0rvalid_post: got %b want 0", M0RValid); else n_pass++;
    n_total++; if (M1RValid !== 1'b0) $display("FAIL rr_m1rvalid_post: got %b want 0", M1RValid); else n_pass++;
    n_total++; if (M0Gnt !== 1'b1) $display("FAIL rr_m0gnt_tie: got %b want 1", M0Gnt); else n_pass++;
    n_total++; if (M1Gnt !== 1'b0) $display("FAIL rr_m1gnt_tie: got %b want 0", M1Gnt); else n_pass++;
    step();
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    step();
  endtask

  initial begin
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    Rst = 1'b1;
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    test_reset();
    test_single_read();
    test_lock();
    test_back_to_back();
    test_timeout();
    test_reset_during_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
